// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared widths, FSM state and owner encodings for ram_arbiter
package ram_arb_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;
endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way picker: lone request wins, ties go to the side not granted last
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic   a_req_i,
    input  logic   b_req_i,
    input  owner_e last_owner_i,
    input  logic   fixed_prio_i,
    output owner_e winner_o
);
    always_comb begin
        winner_o = OWN_A;
        if (a_req_i && b_req_i) begin
            winner_o = (fixed_prio_i || last_owner_i == OWN_B) ? OWN_A : OWN_B;
        end else if (b_req_i) begin
            winner_o = OWN_B;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester single-port RAM arbiter; RAM_ARB_FIXED_PRIO_EN makes A always win ties
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              aReq,
    input  logic              bReq,
    input  logic              aWE,
    input  logic              bWE,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [DATA_W-1:0] aDataIn,
    input  logic [DATA_W-1:0] bDataIn,
    output logic              aGnt,
    output logic              bGnt,
    output logic              aRdValid,
    output logic              bRdValid,
    output logic [DATA_W-1:0] aRdData,
    output logic [DATA_W-1:0] bRdData,
    output logic [ADDR_W-1:0] ramAddress,
    output logic              ramWE,
    output logic [DATA_W-1:0] ramDataIn,
    input  logic [DATA_W-1:0] ramDataOut
);
    state_e            state_q, state_d;
    owner_e            owner_q, winner, last_owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              latch;
    logic              fixed_prio;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign fixed_prio = 1'b1;
    assign last_owner = OWN_B;
`else
    owner_e last_q;

    assign fixed_prio = 1'b0;
    assign last_owner = last_q;

    // Reset value B hands the first tie to A.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            last_q <= OWN_B;
        end else if (latch) begin
            last_q <= winner;
        end
    end
`endif

    rr_pick2 u_pick (
        .a_req_i      (aReq),
        .b_req_i      (bReq),
        .last_owner_i (last_owner),
        .fixed_prio_i (fixed_prio),
        .winner_o     (winner)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            owner_q <= OWN_A;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                owner_q <= winner;
                we_q    <= (winner == OWN_A) ? aWE : bWE;
                addr_q  <= (winner == OWN_A) ? aAddr : bAddr;
                data_q  <= (winner == OWN_A) ? aDataIn : bDataIn;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        aGnt     = 1'b0;
        bGnt     = 1'b0;
        aRdValid = 1'b0;
        bRdValid = 1'b0;
        aRdData  = '0;
        bRdData  = '0;
        ramWE    = 1'b0;
        case (state_q)
            IDLE: begin
                if (aReq || bReq) begin
                    latch   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                aGnt    = (owner_q == OWN_A);
                bGnt    = (owner_q == OWN_B);
                ramWE   = we_q;
                state_d = we_q ? IDLE : RDATA;
            end
            RDATA: begin
                // RAM output is registered, so read data lands one cycle after ACCESS.
                aRdValid = (owner_q == OWN_A);
                bRdValid = (owner_q == OWN_B);
                aRdData  = (owner_q == OWN_A) ? ramDataOut : '0;
                bRdData  = (owner_q == OWN_B) ? ramDataOut : '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ramAddress = addr_q;
    assign ramDataIn  = data_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed bench for ram_arbiter against a transaction-schedule model
module tb_ram_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          resetN = 1'b1;
    logic          aReq = 1'b0, bReq = 1'b0, aWE = 1'b0, bWE = 1'b0;
    logic [AW-1:0] aAddr = '0, bAddr = '0;
    logic [DW-1:0] aDataIn = '0, bDataIn = '0;
    logic          aGnt, bGnt, aRdValid, bRdValid, ramWE;
    logic [DW-1:0] aRdData, bRdData, ramDataIn;
    logic [DW-1:0] ramDataOut = '0;
    logic [AW-1:0] ramAddress;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .resetN(resetN),
        .aReq(aReq), .bReq(bReq), .aWE(aWE), .bWE(bWE),
        .aAddr(aAddr), .bAddr(bAddr), .aDataIn(aDataIn), .bDataIn(bDataIn),
        .aGnt(aGnt), .bGnt(bGnt), .aRdValid(aRdValid), .bRdValid(bRdValid),
        .aRdData(aRdData), .bRdData(bRdData),
        .ramAddress(ramAddress), .ramWE(ramWE), .ramDataIn(ramDataIn),
        .ramDataOut(ramDataOut)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM; cleared while reset is held across an edge.
    logic [DW-1:0] ram [32];
    always @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < 32; i++) ram[i] <= '0;
        end else begin
            if (ramWE) ram[ramAddress] <= ramDataIn;
            ramDataOut <= ram[ramAddress];
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: an access started at edge e grants in the following cycle; reads deliver data one cycle
    // later; the arbiter then stays deaf for 1 (write) or 2 (read) further edges.
    int            busy;
    bit            pend, p_owner, m_last;
    logic [DW-1:0] p_data;
    logic [DW-1:0] mem [32];
    bit            exp_ga, exp_gb, exp_va, exp_vb, exp_act, exp_we;
    logic [DW-1:0] exp_rd, exp_wd;
    logic [AW-1:0] exp_addr;
    bit            auto_a, auto_b, keep_a, keep_b, rst_on_ga, rst_fired;

    function automatic void model_clear_outputs();
        exp_ga = 0; exp_gb = 0; exp_va = 0; exp_vb = 0; exp_act = 0; exp_we = 0;
    endfunction

    function automatic void model_reset();
        model_clear_outputs();
        busy = 0; pend = 0; m_last = 1;
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endfunction

    function automatic void model_edge();
        bit w;
        model_clear_outputs();
        if (pend) begin
            if (p_owner) exp_vb = 1; else exp_va = 1;
            exp_rd = p_data;
            pend = 0;
        end
        if (busy > 0) begin
            busy--;
        end else if (aReq || bReq) begin
            if (aReq && bReq) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                w = 0;
`else
                w = !m_last;
`endif
            end else begin
                w = !aReq;
            end
            m_last   = w;
            exp_act  = 1;
            exp_we   = w ? bWE : aWE;
            exp_addr = w ? bAddr : aAddr;
            exp_wd   = w ? bDataIn : aDataIn;
            if (w) exp_gb = 1; else exp_ga = 1;
            if (exp_we) begin
                mem[exp_addr] = exp_wd;
                busy = 1;
            end else begin
                pend = 1; p_owner = w; p_data = mem[exp_addr];
                busy = 2;
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_aGnt"}, aGnt, 0);
        check_eq({tag, "_bGnt"}, bGnt, 0);
        check_eq({tag, "_aRdValid"}, aRdValid, 0);
        check_eq({tag, "_bRdValid"}, bRdValid, 0);
        check_eq({tag, "_aRdData"}, aRdData, 0);
        check_eq({tag, "_bRdData"}, bRdData, 0);
        check_eq({tag, "_ramWE"}, ramWE, 0);
        check_eq({tag, "_ramAddress"}, ramAddress, 0);
        check_eq({tag, "_ramDataIn"}, ramDataIn, 0);
    endtask

    task automatic cycle();
        @(posedge clock);
        if (resetN) model_edge(); else model_reset();
        @(negedge clock);
        check_eq("aGnt", aGnt, exp_ga);
        check_eq("bGnt", bGnt, exp_gb);
        check_eq("aRdValid", aRdValid, exp_va);
        check_eq("bRdValid", bRdValid, exp_vb);
        check_eq("ramWE", ramWE, exp_act && exp_we);
        if (exp_va) check_eq("aRdData", aRdData, exp_rd);
        if (exp_vb) check_eq("bRdData", bRdData, exp_rd);
        if (exp_act) check_eq("ramAddress", ramAddress, exp_addr);
        if (exp_act && exp_we) check_eq("ramDataIn", ramDataIn, exp_wd);
        if (rst_on_ga && exp_ga) begin
            resetN = 1'b0;
            #1;
            check_all_zero("abort");
            model_reset();
            rst_on_ga = 0; rst_fired = 1;
            aReq = 1'b0;
        end
        if (aReq && exp_ga && !keep_a) aReq = 1'b0;
        if (bReq && exp_gb && !keep_b) bReq = 1'b0;
        if (auto_a && !aReq && $urandom_range(0, 99) < 40) begin
            aReq = 1'b1; aWE = 1'($urandom); aAddr = AW'($urandom); aDataIn = DW'($urandom);
        end
        if (auto_b && !bReq && $urandom_range(0, 99) < 40) begin
            bReq = 1'b1; bWE = 1'($urandom); bAddr = AW'($urandom); bDataIn = DW'($urandom);
        end
    endtask

    task automatic req_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        aReq = 1'b1; aWE = we; aAddr = addr; aDataIn = data;
    endtask

    task automatic req_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bReq = 1'b1; bWE = we; bAddr = addr; bDataIn = data;
    endtask

    task automatic drain();
        keep_a = 0; keep_b = 0;
        repeat (6) cycle();
        aReq = 1'b0; bReq = 1'b0;
        repeat (4) cycle();
    endtask

    initial begin
        auto_a = 0; auto_b = 0; keep_a = 0; keep_b = 0; rst_on_ga = 0; rst_fired = 0;
        model_reset();
        #2 resetN = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) cycle();
        resetN = 1'b1;
        cycle();

        // A writes A5 to 3, then reads it back.
        req_a(1'b1, 5'd3, 8'hA5);
        repeat (4) cycle();
        req_a(1'b0, 5'd3, 8'h00);
        repeat (5) cycle();
        check_eq("mem3_model", mem[3], 8'hA5);

        // A alone makes lastOwner=A, then a same-cycle tie with B writing 3C to 31.
        req_a(1'b0, 5'd1, 8'h00);
        repeat (5) cycle();
        req_a(1'b0, 5'd3, 8'h00);
        req_b(1'b1, 5'd31, 8'h3C);
        repeat (8) cycle();
        drain();

        // A keeps its write request high after the grant: back-to-back writes.
        keep_a = 1;
        req_a(1'b1, 5'd7, 8'h5A);
        repeat (7) cycle();
        drain();

        // Both requesters hold read requests.
        keep_a = 1; keep_b = 1;
        req_a(1'b0, 5'd3, 8'h00);
        req_b(1'b0, 5'd31, 8'h00);
        repeat (13) cycle();
        drain();

        // Reset in the ACCESS cycle of an A read, then a tie.
        req_a(1'b0, 5'd3, 8'h00);
        rst_on_ga = 1;
        for (int i = 0; i < 10 && !rst_fired; i++) cycle();
        check_eq("reset_fired", rst_fired, 1);
        cycle();
        resetN = 1'b1;
        cycle();
        req_a(1'b0, 5'd2, 8'h00);
        req_b(1'b0, 5'd4, 8'h00);
        repeat (8) cycle();
        drain();

        // Randomized traffic with occasional held requests.
        auto_a = 1; auto_b = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                keep_a = 1'($urandom); keep_b = 1'($urandom);
            end
            cycle();
        end
        auto_a = 0; auto_b = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5: RAM address width, 32 words.
REQ-002 Parameter DATA_W, default 8: RAM data width.
REQ-003 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 Port clock, input, 1: sole clock; all state updates on posedge.
REQ-005 Port resetN, input, 1: asynchronous active-low reset.
REQ-006 Ports aReq/bReq, input, 1: requester A (instruction fetch) / B (data) access request.
REQ-007 Ports aWE/bWE, input, 1: 1 = write, 0 = read.
REQ-008 Ports aAddr/bAddr, input, ADDR_W: access address.
REQ-009 Ports aDataIn/bDataIn, input, DATA_W: write data.
REQ-010 Ports aGnt/bGnt, output, 1: one-cycle grant pulse.
REQ-011 Ports aRdValid/bRdValid, output, 1: one-cycle read-data-valid pulse.
REQ-012 Ports aRdData/bRdData, output, DATA_W: read data, meaningful only while the matching RdValid is high.
REQ-013 Ports ramAddress (output, ADDR_W), ramWE (output, 1), ramDataIn (output, DATA_W), ramDataOut (input, DATA_W): single-port RAM side; the RAM registers its read data one cycle after the address.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS and RDATA.
REQ-015 In IDLE with any xReq high, the winner's WE/Addr/DataIn and its owner id SHALL be latched at the clock edge, and the FSM SHALL enter ACCESS.
REQ-016 In ACCESS, ramAddress/ramWE/ramDataIn SHALL be driven from the latched fields, and the owner's xGnt SHALL be 1 for exactly this cycle.
REQ-017 From ACCESS: a write SHALL go to IDLE; a read SHALL go to RDATA.
REQ-018 In RDATA, the owner's xRdValid SHALL be 1 and xRdData SHALL equal ramDataOut, and the FSM SHALL then go to IDLE.
REQ-019 Latency: write = grant 1 cycle after the request is sampled; read data = 2 cycles after the request is sampled; occupancy SHALL be 2 cycles per write and 3 per read.
REQ-020 A requester SHALL hold xReq and its fields stable until it sees xGnt; the block SHALL ignore xReq in ACCESS and RDATA.
REQ-021 A request still high in the cycle xGnt is seen SHALL be treated as a new request when the FSM returns to IDLE.
REQ-022 ramWE SHALL be 0 in every state except ACCESS with a latched write; ramAddress and ramDataIn SHALL hold their last latched values otherwise.
REQ-023 When both requests are high in IDLE, the winner SHALL be the requester not granted last (round-robin); lastOwner SHALL update on each latch.
REQ-024 When exactly one request is high, it SHALL win regardless of lastOwner.
REQ-025 Neither requester SHALL wait more than one other access under round-robin.
REQ-026 xRdValid and xGnt SHALL never be high for the non-owner, and SHALL never be high for both ports in the same cycle.

Reset
REQ-027 On resetN low, the FSM SHALL go to IDLE immediately, and all Gnt, RdValid, RdData, ramWE, ramAddress and ramDataIn outputs SHALL be 0.
REQ-028 On resetN low, lastOwner SHALL be B, so that A wins the first tie.
REQ-029 Reset during ACCESS SHALL abort the access; a write in progress is not guaranteed to land, and no RdValid SHALL follow.

Configuration
REQ-030 With RAM_ARB_FIXED_PRIO_EN defined, A SHALL always win ties and lastOwner SHALL not be implemented.
REQ-031 Without RAM_ARB_FIXED_PRIO_EN, round-robin per REQ-023 SHALL apply.

Structure
REQ-032 Package ram_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the state encoding (IDLE=0, ACCESS=1, RDATA=2) and the owner encoding (OWN_A=0, OWN_B=1).
REQ-033 Sub-module rr_pick2 SHALL be a combinational 2-way picker taking reqs, lastOwner and the fixed-priority select, and returning the winner.

Verification
REQ-034 Test: A writes 8'hA5 to address 5'd3, then A reads 5'd3 -> aGnt pulses once for each access; aRdValid rises 2 cycles after the read request is sampled with aRdData=8'hA5; bGnt and bRdValid stay 0.
REQ-035 Test: aReq and bReq both held, both reading, from reset -> grants alternate A,B,A,B at a 3-cycle spacing; with RAM_ARB_FIXED_PRIO_EN and aReq held high, bGnt is never asserted.
REQ-036 Test: B writes 8'h3C to address 5'd31, with A requesting in the same cycle and lastOwner=A -> B is granted first; ramWE is high only in B's ACCESS cycle; A is granted 2 cycles later.
REQ-037 Test: resetN pulled low during the ACCESS cycle of an A read -> all outputs go to 0 immediately; no aRdValid follows; the next tie after reset goes to A.
REQ-038 Test: A holds aReq high after its write grant -> a second write is granted 2 cycles after the first; with no B request, there is no extra idle cycle beyond IDLE.
